mips_exec_ctrl: RTL and testbench

- Execution sequencer for the 5-stage MIPS pipeline, driven by the debug unit.
- Gates the global pipeline enable and controls run, single-step, pause, restart-with-flush and halt-on-program-end.
- Counts executed clock cycles for reporting back over the debug link.
- Sits between the debug unit's command interface and the enable/flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/mips_exec_ctrl.sv | 151 +++++++++++++++
 tb/tb_mips_exec_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_ctrl.sv
// Execution sequencer for the 5-stage MIPS pipeline: run / step / pause / restart-with-flush / halt.
// Latency: a command accepted at edge k shows its new state's outputs in the cycle after edge k.
// Backpressure: o_cmd_ready is low in STEP and FLUSH; all outputs decode from registered state only.
// Optional cycle watchdog: define MIPS_EXEC_CYCLE_LIMIT_EN (o_timeout tied 0 when undefined).
module mips_exec_ctrl #(
  parameter int NB_CMD     = 2,
  parameter int NB_CYCLES  = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic [NB_CMD-1:0]    i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_halt,
  output logic                 o_pipe_en,
  output logic                 o_pipe_flush,
  output logic                 o_done,
  output logic                 o_step_done,
  output logic                 o_timeout,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [NB_CMD-1:0]    CMD_RUN  = NB_CMD'(1);
  localparam logic [NB_CMD-1:0]    CMD_STEP = NB_CMD'(2);
  localparam logic [NB_CMD-1:0]    CMD_STOP = NB_CMD'(3);
  localparam logic [NB_CYCLES-1:0] LIMIT    = NB_CYCLES'(MAX_CYCLES - 1);

`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  state_t               state;
  state_t               state_next;
  logic                 pend_step;       // target after FLUSH: 1 = STEP, 0 = RUN
  logic                 pend_step_next;
  logic                 step_done;
  logic [NB_CYCLES-1:0] cnt;

  logic accept;
  logic halt_eff;
  logic cnt_sat;
  logic limit_hit;

  assign accept   = i_cmd_valid && o_cmd_ready;
  // HALT in WB only means something while the pipeline is actually advancing
  assign halt_eff = i_halt && o_pipe_en;
  assign cnt_sat  = &cnt;
  // Watchdog fires on the edge that would take the count from MAX-1 to MAX
  assign limit_hit = LIMIT_EN && (state == S_RUN) && (cnt == LIMIT) && !cnt_sat;

  // State and pending-target registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pend_step <= 1'b0;
    end else begin
      state     <= state_next;
      pend_step <= pend_step_next;
    end
  end

  // Next-state logic and capture of the restart target when leaving DONE
  always_comb begin
    state_next     = state;
    pend_step_next = pend_step;
    case (state)
      S_IDLE: begin
        if (accept && i_cmd == CMD_RUN)       state_next = S_RUN;
        else if (accept && i_cmd == CMD_STEP) state_next = S_STEP;
      end
      S_RUN: begin
        if (halt_eff)                         state_next = S_DONE;
        else if (limit_hit)                   state_next = S_DONE;
        else if (accept && i_cmd == CMD_STOP) state_next = S_IDLE;
      end
      S_STEP: begin
        state_next = halt_eff ? S_DONE : S_IDLE;
      end
      S_FLUSH: begin
        state_next = pend_step ? S_STEP : S_RUN;
      end
      S_DONE: begin
        if (accept && (i_cmd == CMD_RUN || i_cmd == CMD_STEP)) begin
          state_next     = S_FLUSH;
          pend_step_next = (i_cmd == CMD_STEP);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the current state
  always_comb begin
    o_pipe_en    = 1'b0;
    o_pipe_flush = 1'b0;
    o_done       = 1'b0;
    o_cmd_ready  = 1'b0;
    case (state)
      S_IDLE:  o_cmd_ready = 1'b1;
      S_RUN:   begin o_pipe_en = 1'b1; o_cmd_ready = 1'b1; end
      S_STEP:  o_pipe_en = 1'b1;
      S_FLUSH: o_pipe_flush = 1'b1;
      S_DONE:  begin o_done = 1'b1; o_cmd_ready = 1'b1; end
      default: ;
    endcase
  end

  // Step-done pulse lands in the first cycle of the state after STEP
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) step_done <= 1'b0;
    else       step_done <= (state == S_STEP);
  end

  assign o_step_done = step_done;

  // Saturating count of enabled cycles, restarted when the flush completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      cnt <= '0;
    else if (state == S_FLUSH)      cnt <= '0;
    else if (o_pipe_en && !cnt_sat) cnt <= cnt + 1'b1;
  end

  assign o_cycle_count = cnt;

`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
  logic timeout;

  // Sticky watchdog flag; a simultaneous HALT counts as a normal finish
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       timeout <= 1'b0;
    else if (state == S_FLUSH)       timeout <= 1'b0;
    else if (limit_hit && !halt_eff) timeout <= 1'b1;
  end

  assign o_timeout = timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: scenario tasks with randomized run lengths.
// Expected counts come from plain arithmetic on the number of enabled cycles.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_mips_exec_ctrl;

  localparam int NB_CMD = 2;
  localparam int NB_CYC = 6;
  localparam int MAXC   = 16;
  localparam int SAT    = (1 << NB_CYC) - 1;
`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  localparam logic [1:0] C_NOP = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_STOP = 2'd3;

  // observed flag vector: {pipe_en, pipe_flush, done, cmd_ready, step_done}
  localparam logic [4:0] V_IDLE    = 5'b00010;
  localparam logic [4:0] V_IDLE_SD = 5'b00011;
  localparam logic [4:0] V_RUN     = 5'b10010;
  localparam logic [4:0] V_STEP    = 5'b10000;
  localparam logic [4:0] V_FLUSH   = 5'b01000;
  localparam logic [4:0] V_DONE    = 5'b00110;
  localparam logic [4:0] V_DONE_SD = 5'b00111;

  logic              i_clk;
  logic              i_rst;
  logic              i_cmd_valid;
  logic [NB_CMD-1:0] i_cmd;
  logic              o_cmd_ready;
  logic              i_halt;
  logic              o_pipe_en;
  logic              o_pipe_flush;
  logic              o_done;
  logic              o_step_done;
  logic              o_timeout;
  logic [NB_CYC-1:0] o_cycle_count;
  logic [4:0]        obs;

  int n_pass  = 0;
  int n_total = 0;

  assign obs = {o_pipe_en, o_pipe_flush, o_done, o_cmd_ready, o_step_done};

  mips_exec_ctrl #(.NB_CMD(NB_CMD), .NB_CYCLES(NB_CYC), .MAX_CYCLES(MAXC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .o_pipe_en(o_pipe_en),
    .o_pipe_flush(o_pipe_flush), .o_done(o_done), .o_step_done(o_step_done),
    .o_timeout(o_timeout), .o_cycle_count(o_cycle_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    cyc();
    i_cmd_valid = 1'b0;
    i_cmd       = C_NOP;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #3;
    i_rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = C_NOP; i_halt = 1'b0;
    #12;
    n_total++;
    if (obs !== V_IDLE) $display("FAIL reset_flags: got %b want %b", obs, V_IDLE); else n_pass++;
    n_total++;
    if (o_cycle_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", o_cycle_count); else n_pass++;
    n_total++;
    if (o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", o_timeout); else n_pass++;
    i_rst = 1'b0;
    cyc();
    n_total++;
    if (obs !== V_IDLE) $display("FAIL post_reset_flags: got %b want %b", obs, V_IDLE); else n_pass++;
  endtask

  task automatic test_run_halt(input int n);
    do_reset();
    send(C_RUN);
    n_total++;
    if (obs !== V_RUN) $display("FAIL run_enter: got %b want %b", obs, V_RUN); else n_pass++;
    repeat (n - 1) cyc();
    n_total++;
    if (o_cycle_count !== 6'(n - 1) || obs !== V_RUN)
      $display("FAIL run_progress: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, n - 1, V_RUN);
    else n_pass++;
    i_halt = 1'b1;
    cyc();
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'(n))
      $display("FAIL run_halt: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, n, V_DONE);
    else n_pass++;
    // halt stays high in DONE: ignored, count holds
    repeat (2) cyc();
    i_halt = 1'b0;
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'(n))
      $display("FAIL done_hold: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, n, V_DONE);
    else n_pass++;
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      // halt while idle must be ignored
      i_halt = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) cyc();
      i_halt = 1'b0;
      n_total++;
      if (obs !== V_IDLE) $display("FAIL step_idle_%0d: got %b want %b", i, obs, V_IDLE); else n_pass++;
      send(C_STEP);
      n_total++;
      if (obs !== V_STEP || o_cycle_count !== 6'(i))
        $display("FAIL step_active_%0d: got cnt %0d flags %b want cnt %0d flags %b", i, o_cycle_count, obs, i, V_STEP);
      else n_pass++;
      cyc();
      n_total++;
      if (obs !== V_IDLE_SD || o_cycle_count !== 6'(i + 1))
        $display("FAIL step_pulse_%0d: got cnt %0d flags %b want cnt %0d flags %b", i, o_cycle_count, obs, i + 1, V_IDLE_SD);
      else n_pass++;
      cyc();
      n_total++;
      if (obs !== V_IDLE) $display("FAIL step_pulse_end_%0d: got %b want %b", i, obs, V_IDLE); else n_pass++;
    end
    send(C_STEP);
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
    n_total++;
    if (obs !== V_DONE_SD || o_cycle_count !== 6'd4)
      $display("FAIL step_halt: got cnt %0d flags %b want cnt 4 flags %b", o_cycle_count, obs, V_DONE_SD);
    else n_pass++;
    cyc();
    n_total++;
    if (obs !== V_DONE) $display("FAIL step_halt_end: got %b want %b", obs, V_DONE); else n_pass++;
  endtask

  task automatic test_pause(input int a, input int b);
    do_reset();
    send(C_RUN);
    repeat (a - 2) cyc();
    send(C_STEP);           // ignored while running
    n_total++;
    if (obs !== V_RUN || o_cycle_count !== 6'(a - 1))
      $display("FAIL pause_step_ignored: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, a - 1, V_RUN);
    else n_pass++;
    send(C_STOP);
    n_total++;
    if (obs !== V_IDLE || o_cycle_count !== 6'(a))
      $display("FAIL pause_stop: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, a, V_IDLE);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_total++;
      if (obs !== V_IDLE || o_cycle_count !== 6'(a))
        $display("FAIL pause_hold_%0d: got cnt %0d flags %b want cnt %0d flags %b", i, o_cycle_count, obs, a, V_IDLE);
      else n_pass++;
    end
    send(C_RUN);
    n_total++;
    if (obs !== V_RUN || o_cycle_count !== 6'(a))
      $display("FAIL pause_resume: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, a, V_RUN);
    else n_pass++;
    repeat (b - 1) cyc();
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'(a + b))
      $display("FAIL pause_final: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, a + b, V_DONE);
    else n_pass++;
  endtask

  task automatic test_restart(input int m);
    do_reset();
    send(C_RUN);
    repeat (m - 1) cyc();
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
    send(C_STOP);           // no effect in DONE
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'(m))
      $display("FAIL done_stop: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, m, V_DONE);
    else n_pass++;
    send(C_RUN);
    n_total++;
    if (obs !== V_FLUSH || o_cycle_count !== 6'(m))
      $display("FAIL restart_flush: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, m, V_FLUSH);
    else n_pass++;
    cyc();
    n_total++;
    if (obs !== V_RUN || o_cycle_count !== 6'd0)
      $display("FAIL restart_run: got cnt %0d flags %b want cnt 0 flags %b", o_cycle_count, obs, V_RUN);
    else n_pass++;
    repeat (2) cyc();
    i_halt = 1'b1; i_cmd_valid = 1'b1; i_cmd = C_STOP;
    cyc();
    i_halt = 1'b0; i_cmd_valid = 1'b0; i_cmd = C_NOP;
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'd3)
      $display("FAIL halt_over_stop: got cnt %0d flags %b want cnt 3 flags %b", o_cycle_count, obs, V_DONE);
    else n_pass++;
    send(C_STEP);
    n_total++;
    if (obs !== V_FLUSH) $display("FAIL restep_flush: got %b want %b", obs, V_FLUSH); else n_pass++;
    cyc();
    n_total++;
    if (obs !== V_STEP || o_cycle_count !== 6'd0)
      $display("FAIL restep_step: got cnt %0d flags %b want cnt 0 flags %b", o_cycle_count, obs, V_STEP);
    else n_pass++;
    cyc();
    n_total++;
    if (obs !== V_IDLE_SD || o_cycle_count !== 6'd1)
      $display("FAIL restep_done: got cnt %0d flags %b want cnt 1 flags %b", o_cycle_count, obs, V_IDLE_SD);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    send(C_RUN);
    repeat (4) cyc();
    #3;
    i_rst = 1'b1;
    #1;
    n_total++;
    if (obs !== V_IDLE || o_cycle_count !== 6'd0)
      $display("FAIL async_reset: got cnt %0d flags %b want cnt 0 flags %b", o_cycle_count, obs, V_IDLE);
    else n_pass++;
    #2;
    i_rst = 1'b0;
    send(C_RUN);
    n_total++;
    if (obs !== V_RUN || o_cycle_count !== 6'd0)
      $display("FAIL async_release_run: got cnt %0d flags %b want cnt 0 flags %b", o_cycle_count, obs, V_RUN);
    else n_pass++;
    cyc();
    n_total++;
    if (o_cycle_count !== 6'd1) $display("FAIL async_release_count: got %0d want 1", o_cycle_count); else n_pass++;
  endtask

  task automatic test_limit();
    int exp_cnt;
    bit exp_done;
    do_reset();
    send(C_RUN);
    for (int j = 1; j <= 70; j++) begin
      cyc();
      if (LIM) begin
        exp_cnt  = (j < MAXC) ? j : MAXC;
        exp_done = (j >= MAXC);
      end else begin
        exp_cnt  = (j < SAT) ? j : SAT;
        exp_done = 1'b0;
      end
      n_total++;
      if (o_cycle_count !== 6'(exp_cnt) || o_done !== exp_done || o_timeout !== exp_done)
        $display("FAIL limit_cycle_%0d: got cnt %0d done %b to %b want cnt %0d done %b to %b",
                 j, o_cycle_count, o_done, o_timeout, exp_cnt, exp_done, exp_done);
      else n_pass++;
    end
`ifdef MIPS_EXEC_CYCLE_LIMIT_EN
    send(C_RUN);
    cyc();
    n_total++;
    if (obs !== V_RUN || o_timeout !== 1'b0 || o_cycle_count !== 6'd0)
      $display("FAIL limit_flush_clear: got cnt %0d flags %b to %b want cnt 0 flags %b to 0", o_cycle_count, obs, o_timeout, V_RUN);
    else n_pass++;
    repeat (MAXC - 1) cyc();
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
    n_total++;
    if (obs !== V_DONE || o_timeout !== 1'b0 || o_cycle_count !== 6'(MAXC))
      $display("FAIL limit_halt_same: got cnt %0d flags %b to %b want cnt %0d flags %b to 0", o_cycle_count, obs, o_timeout, MAXC, V_DONE);
    else n_pass++;
`else
    i_halt = 1'b1;
    cyc();
    i_halt = 1'b0;
    n_total++;
    if (obs !== V_DONE || o_cycle_count !== 6'(SAT))
      $display("FAIL sat_halt: got cnt %0d flags %b want cnt %0d flags %b", o_cycle_count, obs, SAT, V_DONE);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_run_halt(20);
    test_run_halt($urandom_range(2, 40));
    test_step();
    test_pause(5, 5);
    test_pause($urandom_range(2, 12), $urandom_range(1, 12));
    test_restart($urandom_range(1, 15));
    test_async_reset();
    test_limit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
